// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide run on operand magnitudes for
// 32 cycles, followed by one sign-correction/select cycle and a one-cycle
// done pulse. busy is the pipeline stall request.
module md_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      MDCode,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] MDResult
);

   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIN,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op;
   logic              neg_res;
   logic [2*XLEN-1:0] acc;     // mul: {product_hi, multiplier}; div: {rem, quo}
   logic [XLEN-1:0]   opb;     // mul: |multiplicand|; div: |divisor|

   // operand preparation for an accepted start
   logic              is_div, sgn_a, sgn_b, neg_a, neg_b;
   logic              div_zero, div_ovf, special_in, neg_in;
   logic [XLEN-1:0]   mag_a, mag_b, opb_in;
   logic [2*XLEN-1:0] acc_in;
   logic              accept;

   // iteration datapath
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     trial, diff;
   logic [2*XLEN-1:0] mul_next, div_next, step;

   // final result selection
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fin_res;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // next-state logic; flush overrides everything, including a new start
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = special_in ? S_FIN : S_CALC;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_CALC:  if (cnt == CNT_LAST) state_next = S_FIN;
         S_FIN:   state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
      if (flush) begin
         state_next = S_IDLE;
         accept     = 1'b0;
      end
   end

   // signedness, magnitudes and special-case detection on the raw inputs.
   // Special cases preload acc so that the ordinary FIN selection yields
   // the architected quotient/remainder with no extra result path.
   always_comb begin
      is_div     = MDCode[2];
      sgn_a      = is_div ? ~MDCode[0] : (MDCode != 3'd3);
      sgn_b      = is_div ? ~MDCode[0] : ~MDCode[1];
      neg_a      = sgn_a & A[XLEN-1];
      neg_b      = sgn_b & B[XLEN-1];
      mag_a      = neg_a ? -A : A;
      mag_b      = neg_b ? -B : B;
      div_zero   = is_div & (B == '0);
      div_ovf    = is_div & ~MDCode[0] & (A == MIN_NEG) & (B == '1);
      special_in = div_zero | div_ovf;
      neg_in     = (is_div & MDCode[1]) ? neg_a : (neg_a ^ neg_b);
      opb_in     = is_div ? mag_b : mag_a;
      acc_in     = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      if (div_zero) begin
         neg_in = 1'b0;
         acc_in = {A, {XLEN{1'b1}}};
      end else if (div_ovf) begin
         neg_in = 1'b0;
         acc_in = {{XLEN{1'b0}}, MIN_NEG};
      end
   end

   // one multiply or divide iteration
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};
      trial    = acc[2*XLEN-1:XLEN-1];
      diff     = trial - {1'b0, opb};
      div_next = diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
      step     = op[2] ? div_next : mul_next;
   end

   // sign correction and result selection
   always_comb begin
      prod = neg_res ? -acc : acc;
      quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = neg_res ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op)
         3'd0:       fin_res = prod[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:       fin_res = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5: fin_res = quo;
         default:    fin_res = rem;
      endcase
   end

   // datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         op       <= '0;
         neg_res  <= 1'b0;
         acc      <= '0;
         opb      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         MDResult <= '0;
      end else begin
         busy <= (state_next == S_CALC) || (state_next == S_FIN);
         done <= (state_next == S_DONE);
         if (accept) begin
            op      <= MDCode;
            neg_res <= neg_in;
            acc     <= acc_in;
            opb     <= opb_in;
            cnt     <= '0;
         end else if ((state == S_CALC) && !flush) begin
            acc <= step;
            cnt <= cnt + 1'b1;
         end
         if ((state == S_FIN) && !flush) MDResult <= fin_res;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed self-checking bench for md_unit.
// A transaction-level reference (latency countdown plus arithmetic result)
// is compared with the DUT outputs on every falling clock edge.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  MDCode = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] MDResult;

   int checks = 0;
   int errors = 0;

   md_unit #(.XLEN(32), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .MDCode(MDCode),
      .A(A), .B(B), .flush(flush), .busy(busy), .done(done),
      .MDResult(MDResult)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // RV32M result from the ISA rules, using wide plain arithmetic
   function automatic logic [31:0] ref_md(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb, p;
      int ia, ib;
      ia = a;
      ib = b;
      xa = (c == 3'd3) ? {32'h0, a} : {{32{a[31]}}, a};
      xb = (c >= 3'd2) ? {32'h0, b} : {{32{b[31]}}, b};
      p  = xa * xb;
      case (c)
         3'd0: return p[31:0];
         3'd1, 3'd2, 3'd3: return p[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      return c[2] && ((b == 0) || (!c[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
   endfunction

   // reference: cycles of busy remaining, pending result, visible outputs
   int          m_left = 0;
   logic        m_busy = 1'b0, m_done = 1'b0;
   logic [31:0] m_res = '0, m_pend = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_pend = '0;
      end else begin
         m_done = 1'b0;
         if (flush) begin
            m_left = 0;
         end else if (m_left == 0) begin
            if (start) begin
               m_pend = ref_md(MDCode, A, B);
               m_left = is_special(MDCode, A, B) ? 1 : 33;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_res  = m_pend;
            end
         end
         m_busy = (m_left != 0);
      end
   end

   // single compare process against the reference
   always @(negedge clk) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("result", MDResult, m_res);
   end

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return $urandom_range(0, 20);
         4: return -$urandom_range(1, 20);
         default: return $urandom;
      endcase
   endfunction

   // issue in the current cycle, return positioned in the done cycle
   task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input int exp_lat, input bit hold);
      int lat, nb;
      start = 1'b1; MDCode = c; A = a; B = b;
      @(negedge clk);
      start = hold; A = $urandom; B = $urandom; MDCode = 3'($urandom);
      lat = 1; nb = 0;
      while (!done && lat < 60) begin
         if (busy) nb++;
         @(negedge clk);
         lat++;
         if (lat >= 30) start = 1'b0;
         else if (hold) begin A = $urandom; B = $urandom; end
      end
      start = 1'b0;
      chk("latency", lat, exp_lat);
      chk("busy_cycles", nb, exp_lat - 1);
      chk("lit_result", MDResult, lit);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset_result", MDResult, 32'h0);
      @(negedge clk);

      // multiply
      run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0); @(negedge clk);
      run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0); @(negedge clk);
      run_op(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0); @(negedge clk);
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0); @(negedge clk);
      // divide
      run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1'b0); @(negedge clk);
      run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1'b0); @(negedge clk);
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b0); @(negedge clk);
      run_op(3'd7, 32'd100, 32'd7, 32'd2, 34, 1'b0); @(negedge clk);

      // flush in cycle T+10 of a DIVU
      start = 1'b1; MDCode = 3'd5; A = 32'd1000; B = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'h0);
      chk("flush_keep", MDResult, 32'd2);
      repeat (40) begin
         @(negedge clk);
         chk("flush_no_done", {31'b0, done}, 32'h0);
      end

      // special cases
      run_op(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 2, 1'b0); @(negedge clk);
      run_op(3'd6, 32'd5, 32'd0, 32'd5, 2, 1'b0); @(negedge clk);
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0); @(negedge clk);
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2, 1'b0); @(negedge clk);

      // start held during CALC, then flush+start in the DONE cycle
      run_op(3'd0, 32'd12345, 32'd1000, 32'd12345000, 34, 1'b1);
      start = 1'b1; flush = 1'b1; MDCode = 3'd5; A = 32'd9; B = 32'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("done_flush_busy", {31'b0, busy}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("done_flush_no_done", {31'b0, done}, 32'h0);
      end

      // back-to-back: second start issued in the done cycle
      run_op(3'd5, 32'd1000, 32'd3, 32'd333, 34, 1'b0);
      run_op(3'd7, 32'd1000, 32'd3, 32'd1, 34, 1'b0);
      @(negedge clk);

      // asynchronous reset mid-CALC
      start = 1'b1; MDCode = 3'd0; A = 32'd3; B = 32'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'b0, busy}, 32'h0);
      chk("arst_done", {31'b0, done}, 32'h0);
      chk("arst_result", MDResult, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic
      repeat (4000) begin
         @(negedge clk);
         start  = ($urandom_range(0, 3) == 0);
         flush  = ($urandom_range(0, 63) == 0);
         MDCode = 3'($urandom);
         A      = pick_operand();
         B      = pick_operand();
      end
      start = 1'b0; flush = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
